regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the rv32 core, replacing the fixed 2R/1W file. It provides a configurable number of read and write ports, a hardwired-zero x0, and same-cycle write-to-read bypass. It also includes a sequenced bulk-clear engine and a low-priority debug access port with a request/acknowledge handshake. It sits between decode (read addresses) and writeback (write ports), with the debug port driven by the debug module.

## Interface
- DATA_WIDTH, 32, register width in bits
- NB_OF_REGS, 32, number of registers (power of two, ≥4)
- ADDRESS_BIT_WIDTH, 5, log2(NB_OF_REGS)
- NB_RD_PORTS, 2, number of read ports (1–4)
- NB_WR_PORTS, 1, number of write ports (1–2)
- INIT_IDX, 2, register loaded with INIT_VAL on reset/clear (must be ≠0)
- INIT_VAL, 32'h0000_2004, initial stack pointer value
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  block enable
- rd_addr  in  NB_RD_PORTS*ADDRESS_BIT_WIDTH  read addresses, port p at slice p
- rd_data  out  NB_RD_PORTS*DATA_WIDTH  read data, port p at slice p
- we  in  NB_WR_PORTS  per-port write enable
- wr_addr  in  NB_WR_PORTS*ADDRESS_BIT_WIDTH  write addresses
- wr_data  in  NB_WR_PORTS*DATA_WIDTH  write data
- clr_req  in  1  request bulk clear (single-cycle pulse or level)
- clr_busy  out  1  clear sequence in progress
- dbg_req  in  1  debug access request, held until dbg_ack
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  ADDRESS_BIT_WIDTH  debug register index
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_ack  out  1  one-cycle acknowledge
- dbg_rdata  out  DATA_WIDTH  debug read data, valid when dbg_ack=1

## Operation
- Reset (rstn=0, asynchronous): all registers 0 except reg[INIT_IDX]=INIT_VAL; FSM IDLE; clear counter 0; clr_busy=0, dbg_ack=0, dbg_rdata=0. Reset during CLEAR aborts it.
- x0: reads always return 0; writes to address 0 from any source are discarded.
- Reads are combinational. rd_data = 0 when en=0 or clr_busy=1. Otherwise, if any we[w]=1 with wr_addr[w]==rd_addr[p]≠0, the port returns the write data (bypass); else it returns reg[rd_addr[p]].
- Writes: on a rising edge with en=1 and clr_busy=0, reg[wr_addr[w]] ← wr_data[w] for every we[w]=1.
- Write conflict: the same address on both ports resolves to the higher port index, for both the array write and the bypass.
- FSM states IDLE, CLEAR.
  - IDLE→CLEAR on an edge with en=1 and clr_req=1. The counter loads 1 and clr_busy rises next cycle.
  - In CLEAR with en=1, each edge writes reg[cnt] ← (cnt==INIT_IDX ? INIT_VAL : 0), then cnt+1.
  - On the edge writing cnt=NB_OF_REGS-1, the FSM returns to IDLE and clr_busy falls.
  - en=0 freezes the FSM and counter. clr_req while in CLEAR is ignored.
- Debug accept condition, evaluated per edge: en=1, FSM IDLE, clr_req=0, no we[w]=1, dbg_req=1, and dbg_ack currently 0.
  - On accept: dbg_rdata ← reg[dbg_addr] (pre-write value; 0 for x0). If dbg_we=1, reg[dbg_addr] ← dbg_wdata.
  - dbg_ack=1 for the following cycle only.
  - Core writes and clr_req take priority; the debug request waits, holding its inputs stable.
- dbg_rdata holds its value until the next accept.

## Timing
- Read latency 0 cycles; bypassed data is visible in the write cycle.
- Array write visible via normal read path 1 edge after the write.
- Clear: clr_busy high for exactly NB_OF_REGS-1 enabled cycles (31 at defaults). Writes are dropped and reads return 0 throughout.
- Debug: dbg_ack arrives 1 cycle after acceptance. The ack cycle never accepts, so debug throughput is at most one access per 2 cycles.
- Widths: all data paths are DATA_WIDTH, with no truncation or extension; addresses ≥ NB_OF_REGS cannot occur.

## Test plan
- Reset release: read x2 → 32'h0000_2004, x5 → 0, clr_busy=0, dbg_ack=0.
- Port 0 writes x5=32'hDEAD_BEEF while rd_addr0=5 → rd_data0=32'hDEAD_BEEF in the same cycle; after the edge, a read of x5 still returns it. A write to x0 of 32'h1 → x0 still reads 0.
- NB_WR_PORTS=2, both ports write x7 (32'h1111 on port 0, 32'h2222 on port 1) → bypass and stored value are both 32'h2222.
- Load x2–x31 with nonzero values, pulse clr_req → clr_busy high for 31 cycles, writes during it ignored; afterwards x2=32'h0000_2004 and all others 0.
- Debug write x9=32'h55 while we=1 for 3 cycles → dbg_ack only 1 cycle after we drops. A following debug read of x9 returns dbg_rdata=32'h55.
- Assert rstn=0 mid-clear (cnt=10) → clr_busy=0 immediately; after release, registers are at reset values and the FSM is IDLE. With en=0, reads return 0 and writes are lost.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline/debug module (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned ADDRESS_BIT_WIDTH = 5,
  parameter int unsigned NB_RD_PORTS       = 2,
  parameter int unsigned NB_WR_PORTS       = 1
);
  logic                                   en;
  logic [NB_RD_PORTS*ADDRESS_BIT_WIDTH-1:0] rd_addr;
  logic [NB_RD_PORTS*DATA_WIDTH-1:0]        rd_data;
  logic [NB_WR_PORTS-1:0]                   we;
  logic [NB_WR_PORTS*ADDRESS_BIT_WIDTH-1:0] wr_addr;
  logic [NB_WR_PORTS*DATA_WIDTH-1:0]        wr_data;
  logic                                   clr_req;
  logic                                   clr_busy;
  logic                                   dbg_req;
  logic                                   dbg_we;
  logic [ADDRESS_BIT_WIDTH-1:0]           dbg_addr;
  logic [DATA_WIDTH-1:0]                  dbg_wdata;
  logic                                   dbg_ack;
  logic [DATA_WIDTH-1:0]                  dbg_rdata;

  modport master (
    output en, rd_addr, we, wr_addr, wr_data, clr_req,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  rd_data, clr_busy, dbg_ack, dbg_rdata
  );

  modport slave (
    input  en, rd_addr, we, wr_addr, wr_data, clr_req,
           dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output rd_data, clr_busy, dbg_ack, dbg_rdata
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: hardwired x0, write-to-read bypass,
// sequenced bulk clear and a low-priority debug access port.
module regfile_mp #(
  parameter int unsigned            DATA_WIDTH        = 32,
  parameter int unsigned            NB_OF_REGS        = 32,
  parameter int unsigned            ADDRESS_BIT_WIDTH = 5,
  parameter int unsigned            NB_RD_PORTS       = 2,
  parameter int unsigned            NB_WR_PORTS       = 1,
  parameter int unsigned            INIT_IDX          = 2,
  parameter logic [DATA_WIDTH-1:0]  INIT_VAL          = 32'h0000_2004
) (
  input  logic        clk,
  input  logic        rstn,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = ADDRESS_BIT_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NB_OF_REGS - 1);
  localparam logic [AW-1:0] INIT_ADDR = AW'(INIT_IDX);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       regs_q [NB_OF_REGS];
  logic                dbg_ack_q;
  logic [DW-1:0]       dbg_rdata_q;

  logic                busy;
  logic                core_wr_en;
  logic                clr_wr_en;
  logic                dbg_accept;
  logic [NB_RD_PORTS*DW-1:0] rd_data_c;
  logic [AW-1:0]       rd_addr_v;
  logic [DW-1:0]       rd_val_v;

  assign busy       = (state_q == CLEAR);
  assign core_wr_en = bus.en && !busy;
  assign clr_wr_en  = bus.en && busy;
  // Debug only gets the array when nothing else wants it this edge.
  assign dbg_accept = bus.en && (state_q == IDLE) && !bus.clr_req && !(|bus.we)
                      && bus.dbg_req && !dbg_ack_q;

  // Clear sequencer next-state: enable gates all progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_d = CLEAR;
            cnt_d   = AW'(1);
          end
        end
        CLEAR: begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST_IDX) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Combinational read ports; ascending write-port scan lets the higher index win.
  always_comb begin
    rd_data_c = '0;
    rd_addr_v = '0;
    rd_val_v  = '0;
    for (int unsigned p = 0; p < NB_RD_PORTS; p++) begin
      rd_addr_v = bus.rd_addr[p*AW +: AW];
      rd_val_v  = '0;
      if (bus.en && !busy && (rd_addr_v != '0)) begin
        rd_val_v = regs_q[rd_addr_v];
        for (int unsigned w = 0; w < NB_WR_PORTS; w++) begin
          if (bus.we[w] && (bus.wr_addr[w*AW +: AW] == rd_addr_v))
            rd_val_v = bus.wr_data[w*DW +: DW];
        end
      end
      rd_data_c[p*DW +: DW] = rd_val_v;
    end
  end

  // Register array: core writes, clear sequence and debug writes are mutually exclusive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NB_OF_REGS; i++)
        regs_q[i] <= (i == INIT_IDX) ? INIT_VAL : '0;
    end else begin
      if (core_wr_en) begin
        for (int unsigned w = 0; w < NB_WR_PORTS; w++) begin
          if (bus.we[w] && (bus.wr_addr[w*AW +: AW] != '0))
            regs_q[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*DW +: DW];
        end
      end
      if (clr_wr_en)
        regs_q[cnt_q] <= (cnt_q == INIT_ADDR) ? INIT_VAL : '0;
      if (dbg_accept && bus.dbg_we && (bus.dbg_addr != '0))
        regs_q[bus.dbg_addr] <= bus.dbg_wdata;
    end
  end

  // Sequencer state, clear counter and debug response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dbg_ack_q <= dbg_accept;
      if (dbg_accept) dbg_rdata_q <= regs_q[bus.dbg_addr];
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.clr_busy  = busy;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (2 read ports, 2 write ports).
module tb_regfile_mp;

  logic clk;
  logic rstn;

  regfile_mp_if #(.DATA_WIDTH(32), .ADDRESS_BIT_WIDTH(5),
                  .NB_RD_PORTS(2), .NB_WR_PORTS(2)) bus ();

  regfile_mp #(.DATA_WIDTH(32), .NB_OF_REGS(32), .ADDRESS_BIT_WIDTH(5),
               .NB_RD_PORTS(2), .NB_WR_PORTS(2), .INIT_IDX(2),
               .INIT_VAL(32'h0000_2004))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;   // 0/1 rd port, 2 clr_busy, 3 dbg_ack, 4 dbg_rdata
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dbg_q[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0:       return bus.rd_data[31:0];
      1:       return bus.rd_data[63:32];
      2:       return {31'b0, bus.clr_busy};
      3:       return {31'b0, bus.dbg_ack};
      default: return bus.dbg_rdata;
    endcase
  endfunction

  task automatic expect_v(input int kind, input logic [31:0] e, input string name);
    exp_t x;
    x.kind = kind; x.exp = e; x.name = name;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    bus.rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wr(input int w, input logic e, input logic [4:0] a, input logic [31:0] d);
    bus.we[w]              = e;
    bus.wr_addr[w*5 +: 5]  = a;
    bus.wr_data[w*32 +: 32] = d;
  endtask

  task automatic clear_wr();
    set_wr(0, 1'b0, 5'd0, 32'h0);
    set_wr(1, 1'b0, 5'd0, 32'h0);
  endtask

  // Monitor: compare queued expectations mid-cycle, and check debug data on every ack.
  always @(negedge clk) begin
    exp_t        x;
    logic [31:0] a;
    logic [31:0] d;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = actual(x.kind);
      checks++;
      if (a !== x.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", x.name, a, x.exp, $time);
      end
    end
    if (bus.dbg_ack === 1'b1) begin
      checks++;
      if (dbg_q.size() == 0) begin
        failures++;
        $display("FAIL dbg_unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        d = dbg_q.pop_front();
        if (bus.dbg_rdata !== d) begin
          failures++;
          $display("FAIL dbg_rdata: got %h expected %h at %0t", bus.dbg_rdata, d, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.en = 1'b0; bus.rd_addr = '0; bus.we = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_req = 1'b0; bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
    bus.dbg_addr = '0; bus.dbg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    rstn = 1'b1; bus.en = 1'b1;
    set_rd(0, 5'd2); set_rd(1, 5'd5);
    expect_v(0, 32'h0000_2004, "rst_x2");
    expect_v(1, 32'h0, "rst_x5");
    expect_v(2, 32'h0, "rst_busy");
    expect_v(3, 32'h0, "rst_ack");
    expect_v(4, 32'h0, "rst_rdata");
    tick();

    // bypass and stored write, x0 immunity
    set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF); set_rd(0, 5'd5);
    expect_v(0, 32'hDEAD_BEEF, "bypass_x5");
    tick();
    clear_wr();
    expect_v(0, 32'hDEAD_BEEF, "stored_x5");
    tick();
    set_wr(0, 1'b1, 5'd0, 32'h1); set_rd(0, 5'd0);
    expect_v(0, 32'h0, "x0_bypass");
    tick();
    clear_wr();
    expect_v(0, 32'h0, "x0_stored");
    tick();

    // same-address write conflict: port 1 wins
    set_wr(0, 1'b1, 5'd7, 32'h1111); set_wr(1, 1'b1, 5'd7, 32'h2222); set_rd(1, 5'd7);
    expect_v(1, 32'h2222, "conflict_bypass");
    tick();
    clear_wr();
    expect_v(1, 32'h2222, "conflict_stored");
    tick();

    // load x2..x31 then bulk clear
    for (int i = 2; i < 32; i += 2) begin
      set_wr(0, 1'b1, 5'(i), 32'h100 + i);
      set_wr(1, 1'b1, 5'(i + 1), 32'h100 + i + 1);
      tick();
    end
    clear_wr();
    set_rd(0, 5'd31); set_rd(1, 5'd2);
    expect_v(0, 32'h11F, "load_x31");
    expect_v(1, 32'h102, "load_x2");
    bus.clr_req = 1'b1;
    expect_v(2, 32'h0, "busy_before_clear");
    tick();
    bus.clr_req = 1'b0;
    set_rd(1, 5'd3);
    for (int i = 0; i < 31; i++) begin
      set_wr(0, 1'b1, 5'd3, 32'hFFFF_FFFF);
      expect_v(2, 32'h1, "clr_busy_high");
      expect_v(0, 32'h0, "clr_read_zero");
      expect_v(1, 32'h0, "clr_bypass_zero");
      tick();
    end
    clear_wr();
    expect_v(2, 32'h0, "clr_busy_done");
    for (int r = 0; r < 32; r += 2) begin
      set_rd(0, 5'(r)); set_rd(1, 5'(r + 1));
      expect_v(0, (r == 2) ? 32'h0000_2004 : 32'h0, "post_clear_even");
      expect_v(1, 32'h0, "post_clear_odd");
      tick();
    end

    // debug write waits for core writes, ack one cycle after accept
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'h55;
    dbg_q.push_back(32'h0);
    for (int i = 0; i < 3; i++) begin
      set_wr(0, 1'b1, 5'd4, 32'h44);
      expect_v(3, 32'h0, "dbg_ack_blocked");
      tick();
    end
    clear_wr();
    expect_v(3, 32'h0, "dbg_ack_accept_cycle");
    tick();
    expect_v(3, 32'h1, "dbg_wr_ack");
    bus.dbg_req = 1'b0;
    tick();
    expect_v(3, 32'h0, "dbg_ack_one_cycle");
    bus.dbg_we = 1'b0; bus.dbg_req = 1'b1;
    dbg_q.push_back(32'h55);
    tick();
    expect_v(3, 32'h1, "dbg_rd_ack");
    bus.dbg_req = 1'b0;
    set_rd(0, 5'd9); set_rd(1, 5'd4);
    expect_v(0, 32'h55, "dbg_written_x9");
    expect_v(1, 32'h44, "core_written_x4");
    tick();

    // asynchronous reset in the middle of a clear
    set_wr(0, 1'b1, 5'd2, 32'h77); set_wr(1, 1'b1, 5'd20, 32'hABCD);
    tick();
    clear_wr();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (8) tick();
    expect_v(2, 32'h1, "busy_before_rst");
    tick();
    rstn = 1'b0;
    expect_v(2, 32'h0, "busy_async_rst");
    tick();
    rstn = 1'b1;
    set_rd(0, 5'd2); set_rd(1, 5'd20);
    expect_v(2, 32'h0, "busy_after_rst");
    expect_v(0, 32'h0000_2004, "rst_mid_clear_x2");
    expect_v(1, 32'h0, "rst_mid_clear_x20");
    tick();

    // back in IDLE: writes land; en=0 blanks reads and drops writes
    set_wr(0, 1'b1, 5'd6, 32'h66);
    tick();
    clear_wr();
    set_rd(0, 5'd6);
    expect_v(0, 32'h66, "idle_write_x6");
    tick();
    bus.en = 1'b0;
    set_wr(0, 1'b1, 5'd6, 32'h99);
    expect_v(0, 32'h0, "en0_read_zero");
    tick();
    clear_wr();
    bus.en = 1'b1;
    expect_v(0, 32'h66, "en0_write_lost");
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (dbg_q.size() != 0) begin
      failures++;
      $display("FAIL dbg_missing_ack: got %0d pending expected 0", dbg_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
